// File: rtl/tt_ldb_alloc.sv
// Load-data-buffer allocator: contiguous circular grants tagged by scoreboard ID.
// Supports single-entry release, per-owner flush and a global flush that rewinds the pointer.
module tt_ldb_alloc #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NUM_SB = 32,
  localparam int unsigned IW = $clog2(DEPTH),
  localparam int unsigned SW = $clog2(DEPTH) + 1,
  localparam int unsigned OW = $clog2(NUM_SB)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc_valid,
  input  logic [OW-1:0] alloc_sb_id,
  input  logic [SW-1:0] alloc_size,
  output logic          alloc_ack,
  output logic [IW-1:0] alloc_start,
  input  logic          free_valid,
  input  logic [IW-1:0] free_idx,
  input  logic          flush_valid,
  input  logic [OW-1:0] flush_sb_id,
  input  logic          flush_all,
  input  logic [OW-1:0] lookup_sb_id,
  output logic [IW-1:0] lookup_start,
  output logic [SW-1:0] occupancy,
  output logic          full,
  output logic          empty,
  output logic          size_err
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] req_mask, grant_mask, free_mask, flush_mask;
  logic [OW-1:0]    owner_q [DEPTH];
  logic [IW-1:0]    start_q [NUM_SB];
  logic [IW-1:0]    free_ptr_q, free_ptr_d;
  logic [SW-1:0]    occupancy_q, occupancy_d;
  logic             size_err_q, size_err_d;
  logic             size_ok;

  // Per-entry masks: requested window (wrapping distance from free_ptr), release and flush hits.
  always_comb begin
    req_mask   = '0;
    free_mask  = '0;
    flush_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      req_mask[i]   = ({1'b0, IW'(i) - free_ptr_q} < alloc_size);
      free_mask[i]  = free_valid && (free_idx == IW'(i));
      flush_mask[i] = flush_valid && valid_q[i] && (owner_q[i] == flush_sb_id);
    end
  end

  // Grant decision against registered valid bits only; flush_all suppresses any grant.
  always_comb begin
    size_ok    = (alloc_size != '0) && (alloc_size <= SW'(DEPTH));
    alloc_ack  = alloc_valid && size_ok && !flush_all && ((req_mask & valid_q) == '0);
    grant_mask = alloc_ack ? req_mask : '0;
  end

  // Next-state valid vector, pointer, occupancy and sticky size error.
  always_comb begin
    valid_d     = '0;
    free_ptr_d  = free_ptr_q;
    occupancy_d = '0;
    size_err_d  = size_err_q | (alloc_valid & ~size_ok);
    if (flush_all) begin
      valid_d    = '0;
      free_ptr_d = '0;
    end else begin
      // A grant never overlaps a valid entry, so clear-then-set cannot conflict.
      valid_d = (valid_q & ~free_mask & ~flush_mask) | grant_mask;
      if (alloc_ack) begin
        // Size DEPTH truncates to 0 in IW bits, which is the correct modulo advance.
        free_ptr_d = free_ptr_q + alloc_size[IW-1:0];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      occupancy_d = occupancy_d + SW'(valid_d[i]);
    end
  end

  // State registers; reset also discards any grant presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      free_ptr_q  <= '0;
      occupancy_q <= '0;
      size_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        owner_q[i] <= '0;
      end
      for (int s = 0; s < NUM_SB; s++) begin
        start_q[s] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      free_ptr_q  <= free_ptr_d;
      occupancy_q <= occupancy_d;
      size_err_q  <= size_err_d;
      if (alloc_ack) begin
        start_q[alloc_sb_id] <= free_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
          if (req_mask[i]) begin
            owner_q[i] <= alloc_sb_id;
          end
        end
      end
    end
  end

  // Registered status and unbypassed start lookup.
  always_comb begin
    alloc_start  = free_ptr_q;
    lookup_start = start_q[lookup_sb_id];
    occupancy    = occupancy_q;
    full         = (occupancy_q == SW'(DEPTH));
    empty        = (occupancy_q == '0);
    size_err     = size_err_q;
  end

endmodule
